// File: rtl/t03_sprite_layer_display_if.sv
// t03_sprite_layer_display_if: raster, position, bitmap and pixel-output bundle for the sprite layer.
interface t03_sprite_layer_display_if #(
    parameter int N_SPR    = 2,
    parameter int SPR_W    = 15,
    parameter int SPR_H    = 20,
    parameter int PIX_BITS = 8
);
    logic [10:0]                             Hcnt;
    logic [10:0]                             Vcnt;
    logic                                    frame_start;
    logic [N_SPR-1:0]                        pos_we;
    logic [N_SPR*11-1:0]                     pos_x;
    logic [N_SPR*11-1:0]                     pos_y;
    logic [N_SPR-1:0]                        sprite_en;
    logic [N_SPR*SPR_W*SPR_H*PIX_BITS-1:0]   bitmap;
    logic [PIX_BITS-1:0]                     color;
    logic [N_SPR-1:0]                        hit;
    logic                                    any_hit;
    logic                                    collision;

    modport master (
        output Hcnt, Vcnt, frame_start, pos_we, pos_x, pos_y, sprite_en, bitmap,
        input  color, hit, any_hit, collision
    );
    modport slave (
        input  Hcnt, Vcnt, frame_start, pos_we, pos_x, pos_y, sprite_en, bitmap,
        output color, hit, any_hit, collision
    );
endinterface

// File: rtl/t03_sprite_layer_display.sv
// t03_sprite_layer_display: 2-stage sprite renderer with double-buffered positions and collision flag.
// Define T03_SPRITE_TRANSPARENCY_EN to make pixel value 0 transparent in the priority mux.
module t03_sprite_layer_display #(
    parameter int N_SPR    = 2,
    parameter int SPR_W    = 15,
    parameter int SPR_H    = 20,
    parameter int PIX_BITS = 8,
    parameter int SCALE_X  = 1,
    parameter int SCALE_Y  = 4,
    parameter int X_OFF    = 37,
    parameter int Y_OFF    = 29
) (
    input logic clk,
    input logic rst,
    t03_sprite_layer_display_if.slave bus
);
    localparam int LX = $clog2(SCALE_X);
    localparam int LY = $clog2(SCALE_Y);
    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    localparam int BW = $clog2(N_SPR*SPR_W*SPR_H*PIX_BITS);

    logic [10:0]         ax [N_SPR];
    logic [10:0]         ay [N_SPR];
    logic [10:0]         px [N_SPR];
    logic [10:0]         py [N_SPR];
    logic [N_SPR-1:0]    pend_v;
    logic [N_SPR-1:0]    in_box, in1, hv, nz;
    logic [CW-1:0]       c0 [N_SPR];
    logic [CW-1:0]       col1 [N_SPR];
    logic [RW-1:0]       r0 [N_SPR];
    logic [RW-1:0]       row1 [N_SPR];
    logic [BW-1:0]       idx [N_SPR];
    logic [PIX_BITS-1:0] pix [N_SPR];
    logic [PIX_BITS-1:0] c;

    for (genvar g = 0; g < N_SPR; g++) begin : g_spr
        logic [11:0] sx, sy, dx, dy;
        assign sx = 12'(X_OFF) + {1'b0, ax[g]};
        assign sy = 12'(Y_OFF) + {1'b0, ay[g]};
        assign dx = {1'b0, bus.Hcnt} - sx;
        assign dy = {1'b0, bus.Vcnt} - sy;
        // 12-bit origin never overflows, so a box past 2047 simply never matches: clipped
        assign in_box[g] = {1'b0, bus.Hcnt} >= sx && dx < 12'(SPR_W*SCALE_X) &&
                           {1'b0, bus.Vcnt} >= sy && dy < 12'(SPR_H*SCALE_Y);
        assign c0[g] = in_box[g] ? CW'(dx >> LX) : '0;
        assign r0[g] = in_box[g] ? RW'(dy >> LY) : '0;
        assign idx[g] = BW'((g*SPR_W*SPR_H + int'(row1[g])*SPR_W + int'(col1[g])) * PIX_BITS);
        assign pix[g] = bus.bitmap[idx[g] +: PIX_BITS];
        assign nz[g] = hv[g] && pix[g] != '0;
    end

    assign hv = in1 & bus.sprite_en;

    always_comb begin
        c = '0;
        for (int i = N_SPR-1; i >= 0; i--)
`ifdef T03_SPRITE_TRANSPARENCY_EN
            if (nz[i]) c = pix[i];
`else
            if (hv[i]) c = pix[i];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v        <= '0;
            in1           <= '0;
            bus.color     <= '0;
            bus.hit       <= '0;
            bus.any_hit   <= 1'b0;
            bus.collision <= 1'b0;
            for (int i = 0; i < N_SPR; i++) begin
                ax[i]   <= '0;
                ay[i]   <= '0;
                px[i]   <= '0;
                py[i]   <= '0;
                col1[i] <= '0;
                row1[i] <= '0;
            end
        end else begin
            // commit reads the pre-cycle pending value; a same-cycle write re-arms for next frame
            for (int i = 0; i < N_SPR; i++) begin
                if (bus.frame_start && pend_v[i]) begin
                    ax[i] <= px[i];
                    ay[i] <= py[i];
                end
                if (bus.pos_we[i]) begin
                    px[i]     <= bus.pos_x[i*11 +: 11];
                    py[i]     <= bus.pos_y[i*11 +: 11];
                    pend_v[i] <= 1'b1;
                end else if (bus.frame_start) begin
                    pend_v[i] <= 1'b0;
                end
                col1[i] <= c0[i];
                row1[i] <= r0[i];
            end
            in1         <= in_box;
            bus.color   <= c;
            bus.hit     <= hv;
            bus.any_hit <= |hv;
            if ($countones(nz) >= 2) bus.collision <= 1'b1;
            else if (bus.frame_start) bus.collision <= 1'b0;
        end
    end
endmodule

// File: tb/tb_t03_sprite_layer_display.sv
// tb_t03_sprite_layer_display: directed stimulus checked against a frame-level sprite model
// and a set of hand-computed expectations.
module tb_t03_sprite_layer_display;
    localparam int N  = 2;
    localparam int W  = 15;
    localparam int H  = 20;
    localparam int SZ = W*H*8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    t03_sprite_layer_display_if #(.N_SPR(N), .SPR_W(W), .SPR_H(H), .PIX_BITS(8)) bus ();
    t03_sprite_layer_display dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // model: active/pending positions, one-cycle raster snapshot, expected registered outputs
    int       m_ax[N], m_ay[N], m_px[N], m_py[N];
    bit       m_pv[N];
    bit       s1_ok;
    int       s1_h, s1_v;
    int       s1_ax[N], s1_ay[N];
    logic [7:0] e_color;
    logic [1:0] e_hit;
    logic       e_coll;

    always @(posedge clk) begin
        int nzc, sx, sy, col, row;
        bit found;
        logic [7:0] p, pc;
        logic [1:0] hh;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_ax[i] = 0; m_ay[i] = 0; m_px[i] = 0; m_py[i] = 0; m_pv[i] = 0;
            end
            s1_ok = 0; e_color = 0; e_hit = 0; e_coll = 0;
        end else begin
            nzc = 0; found = 0; pc = 0; hh = 0;
            for (int i = 0; i < N; i++) begin
                sx = 37 + s1_ax[i];
                sy = 29 + s1_ay[i];
                if (s1_ok && bus.sprite_en[i] && s1_h >= sx && s1_h < sx + W &&
                    s1_v >= sy && s1_v < sy + H*4) begin
                    col = s1_h - sx;
                    row = (s1_v - sy) / 4;
                    p = bus.bitmap[i*SZ + (row*W + col)*8 +: 8];
                    hh[i] = 1'b1;
                    if (p != 0) nzc++;
`ifdef T03_SPRITE_TRANSPARENCY_EN
                    if (!found && p != 0) begin pc = p; found = 1; end
`else
                    if (!found) begin pc = p; found = 1; end
`endif
                end
            end
            e_color = pc;
            e_hit = hh;
            if (nzc >= 2) e_coll = 1'b1;
            else if (bus.frame_start) e_coll = 1'b0;
            s1_ok = 1; s1_h = int'(bus.Hcnt); s1_v = int'(bus.Vcnt);
            for (int i = 0; i < N; i++) begin
                s1_ax[i] = m_ax[i]; s1_ay[i] = m_ay[i];
            end
            for (int i = 0; i < N; i++) begin
                if (bus.frame_start && m_pv[i]) begin
                    m_ax[i] = m_px[i]; m_ay[i] = m_py[i]; m_pv[i] = 0;
                end
                if (bus.pos_we[i]) begin
                    m_px[i] = int'(bus.pos_x[i*11 +: 11]);
                    m_py[i] = int'(bus.pos_y[i*11 +: 11]);
                    m_pv[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_color", 32'(bus.color), 32'(e_color));
        check("model_hit", 32'(bus.hit), 32'(e_hit));
        check("model_any_hit", 32'(bus.any_hit), 32'(|e_hit));
        check("model_collision", 32'(bus.collision), 32'(e_coll));
    end

    task automatic hold(input int h, input int v, input int n);
        bus.Hcnt = 11'(h);
        bus.Vcnt = 11'(v);
        repeat (n) @(negedge clk);
    endtask

    task automatic wpos(input int i, input int x, input int y, input bit fs);
        bus.pos_we = '0;
        bus.pos_we[i] = 1'b1;
        bus.pos_x[i*11 +: 11] = 11'(x);
        bus.pos_y[i*11 +: 11] = 11'(y);
        bus.frame_start = fs;
        @(negedge clk);
        bus.pos_we = '0;
        bus.frame_start = 1'b0;
    endtask

    task automatic fstart();
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic set_pix(input int s, input int r, input int c, input logic [7:0] p);
        bus.bitmap[s*SZ + (r*W + c)*8 +: 8] = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Hcnt = 11'd40; bus.Vcnt = 11'd30;
        bus.frame_start = 0; bus.pos_we = 0; bus.pos_x = 0; bus.pos_y = 0;
        bus.sprite_en = 0; bus.bitmap = '0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        check("reset_color", 32'(bus.color), 0);
        check("reset_hit", 32'(bus.hit), 0);
        check("reset_collision", 32'(bus.collision), 0);
        bus.sprite_en = 2'b01;
        set_pix(0, 0, 0, 8'hE0);
        set_pix(0, 1, 0, 8'h1C);
        wpos(0, 100, 0, 0);
        hold(37, 29, 2);
        check("pre_frame_pos_zero_hit", 32'(bus.hit), 32'h1);
        check("pre_frame_pos_zero_color", 32'(bus.color), 32'hE0);
        fstart();
        hold(37, 29, 2);
        check("x100_old_spot_hit", 32'(bus.hit), 0);
        hold(137, 29, 2);
        check("x100_hit", 32'(bus.hit), 32'h1);
        check("x100_color", 32'(bus.color), 32'hE0);
        wpos(0, 0, 0, 0);
        fstart();
        hold(200, 200, 2);
        hold(37, 29, 1);
        check("latency_1cyc_hit", 32'(bus.hit), 0);
        hold(37, 29, 1);
        check("latency_2cyc_hit", 32'(bus.hit), 32'h1);
        check("latency_2cyc_color", 32'(bus.color), 32'hE0);
        hold(52, 29, 2);
        check("right_edge_out_hit", 32'(bus.hit), 0);
        check("right_edge_out_color", 32'(bus.color), 0);
        hold(51, 29, 2);
        check("right_edge_in_hit", 32'(bus.hit), 32'h1);
        hold(37, 32, 2);
        check("scale_row0_color", 32'(bus.color), 32'hE0);
        hold(37, 33, 2);
        check("scale_row1_color", 32'(bus.color), 32'h1C);
        hold(37, 108, 2);
        check("bottom_in_hit", 32'(bus.hit), 32'h1);
        hold(37, 109, 2);
        check("bottom_out_hit", 32'(bus.hit), 0);
        wpos(0, 100, 0, 0);
        hold(37, 29, 2);
        check("midframe_write_no_change", 32'(bus.hit), 32'h1);
        fstart();
        hold(137, 29, 2);
        check("after_fs_new_x_hit", 32'(bus.hit), 32'h1);
        hold(37, 29, 2);
        check("after_fs_old_x_miss", 32'(bus.hit), 0);
        wpos(0, 0, 0, 1);
        hold(37, 29, 2);
        check("write_on_fs_deferred", 32'(bus.hit), 0);
        fstart();
        hold(37, 29, 2);
        check("write_on_fs_next_frame", 32'(bus.hit), 32'h1);
        set_pix(0, 0, 0, 8'h00);
        set_pix(1, 0, 0, 8'h03);
        bus.sprite_en = 2'b11;
        wpos(1, 0, 0, 0);
        fstart();
        hold(37, 29, 2);
        check("prio_hit", 32'(bus.hit), 32'h3);
        check("prio_any_hit", 32'(bus.any_hit), 32'h1);
`ifdef T03_SPRITE_TRANSPARENCY_EN
        check("prio_color", 32'(bus.color), 32'h03);
`else
        check("prio_color", 32'(bus.color), 32'h00);
`endif
        check("prio_no_collision", 32'(bus.collision), 0);
        set_pix(0, 0, 0, 8'hE0);
        hold(37, 29, 2);
        check("collision_set", 32'(bus.collision), 32'h1);
        check("collision_color", 32'(bus.color), 32'hE0);
        hold(200, 200, 3);
        check("collision_sticky", 32'(bus.collision), 32'h1);
        fstart();
        check("collision_cleared", 32'(bus.collision), 0);
        wpos(0, 2010, 0, 0);
        fstart();
        hold(2047, 29, 2);
        check("clip_edge_hit", 32'(bus.hit), 32'h1);
        hold(0, 29, 2);
        check("clip_no_wrap", 32'(bus.hit), 0);
        hold(200, 200, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
